multicycle_control_unit: RTL and testbench
==========================================

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have parameter ALUCTRL_W, default 4; alu_control width, >=4, codes zero-extended.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 16; max wait cycles for mem_ready, 0 disables timeout.
REQ-003 SHALL have ports: clk in 1 clock; reset in 1 synchronous active-high reset. One clock; reset is synchronous and active-high.
REQ-004 SHALL have ports: opcode in 6, funct in 6, shamt in 5 (instruction fields); zero in 1 (ALU zero flag); mem_ready in 1 (memory access complete).
REQ-005 SHALL have outputs: ir_write, pc_write, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a (1 each); pc_src 2 (00 pc+4, 01 branch, 10 jal target, 11 register); alu_src_b 2 (00 reg, 01 const 4, 10 imm).
REQ-006 SHALL have outputs: alu_control ALUCTRL_W; state 3; done 1 (instruction retired); illegal 1; fault 1.

Function
REQ-007 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=5; state output shows current state.
REQ-008 FETCH: mem_read=1, alu_src_a=0, alu_src_b=01, pc_src=00; on mem_ready assert ir_write and pc_write same cycle, go DECODE; else stay.
REQ-009 DECODE: latch opcode, funct, shamt into internal registers; EXEC/MEM/WB use only latched values.
REQ-010 DECODE, jal (000011): reg_write=1, pc_write=1, pc_src=10, done=1, go FETCH.
REQ-011 DECODE, jr (000111): pc_write=1, pc_src=11, done=1, go FETCH.
REQ-012 DECODE, unsupported opcode: illegal=1 for one cycle, no write strobe, done=0, go FETCH.
REQ-013 DECODE, R-type (000000), lw (100011), sw (101011), beq (000100), addi (001000): go EXEC.
REQ-014 EXEC, beq: alu_control=0110, alu_src_a=1, alu_src_b=00; pc_write=zero, pc_src=01, done=1, go FETCH.
REQ-015 EXEC, lw/sw/addi: alu_control=0010, alu_src_a=1, alu_src_b=10; lw/sw go MEM, addi go WB.
REQ-016 EXEC, R-type: alu_src_a=1, alu_src_b=00; funct 100000->0010, 100010->0110, 100100->0000, 100101->0001, 101010->0111; other funct -> illegal=1 one cycle, go FETCH; valid go WB.
REQ-017 MEM: lw holds mem_read=1, sw holds mem_write=1 until mem_ready; on mem_ready lw go WB, sw assert done=1, go FETCH.
REQ-018 WB: reg_write=1 one cycle; reg_dst=1 for R-type/DSP, 0 for addi/lw; mem_to_reg=1 only for lw; done=1; go FETCH.
REQ-019 Wait counter SHALL clear on entry to FETCH and MEM, increment each cycle mem_ready=0 there; when MEM_TIMEOUT>0 and count reaches MEM_TIMEOUT without mem_ready, go FAULT next cycle.
REQ-020 mem_ready on the same cycle the count reaches MEM_TIMEOUT SHALL win; access completes normally.
REQ-021 FAULT: fault=1, all strobes 0, state held until reset.
REQ-022 Strobes SHALL be combinational from state and latched fields; unnamed outputs 0 in each state; done/illegal never exceed one cycle.

Reset
REQ-023 reset=1 at a clk edge SHALL force FETCH, clear counter, latched fields and fault, from any state incl. mid-MEM and FAULT.
REQ-024 During and after reset, outputs equal FETCH values: mem_read=1, alu_src_b=01, all others 0.

Configuration
REQ-025 Macro MULTICYCLE_CTRL_DSP_EN defined: opcode 011111 goes EXEC; funct 010000 with shamt 00000 -> alu_control 1000, shamt 01000 -> 1001, goes WB; other funct/shamt -> illegal.
REQ-026 Macro undefined: opcode 011111 treated as unsupported per REQ-012.

Verification
REQ-027 add (opcode 0, funct 100000), mem_ready=1 in FETCH -> states 0,1,2,4,0; alu_control=0010 in EXEC; reg_write=1, reg_dst=1, done=1 in WB.
REQ-028 lw, mem_ready low 3 cycles in MEM -> mem_read held 4 cycles, then WB with mem_to_reg=1, reg_write=1.
REQ-029 beq with zero=1 then zero=0 -> pc_write=1/pc_src=01 first, pc_write=0 second; done=1 both.
REQ-030 MEM_TIMEOUT=4, mem_ready=0 in FETCH -> FAULT after 4 wait cycles, fault=1 held; reset -> FETCH, fault=0.
REQ-031 opcode 011111 funct 010000 shamt 01000: with macro alu_control=1001 and reg_write in WB; without macro illegal=1 in DECODE, no writes.
REQ-032 reset asserted mid-MEM of sw -> next cycle state=0, mem_write=0, mem_read=1.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: multicycle MIPS-style control FSM with memory wait timeout;
// define MULTICYCLE_CTRL_DSP_EN to decode the DSP opcode 011111.
module multicycle_control_unit #(
    parameter int ALUCTRL_W   = 4,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    input  logic [4:0]           shamt,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 reg_write,
    output logic                 reg_dst,
    output logic                 mem_to_reg,
    output logic                 alu_src_a,
    output logic [1:0]           pc_src,
    output logic [1:0]           alu_src_b,
    output logic [ALUCTRL_W-1:0] alu_control,
    output logic [2:0]           state,
    output logic                 done,
    output logic                 illegal,
    output logic                 fault
);
    localparam logic [2:0] FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, FAULT = 3'd5;
    localparam logic [5:0] OP_R = 6'b000000, OP_JAL = 6'b000011, OP_JR = 6'b000111, OP_BEQ = 6'b000100,
        OP_ADDI = 6'b001000, OP_LW = 6'b100011, OP_SW = 6'b101011, OP_DSP = 6'b011111;
    localparam int CW = $clog2(MEM_TIMEOUT + 2);
`ifdef MULTICYCLE_CTRL_DSP_EN
    localparam logic DSP_EN = 1'b1;
`else
    localparam logic DSP_EN = 1'b0;
`endif

    logic [2:0]    st, nxt;
    logic [5:0]    op, fn;
    logic [4:0]    sh;
    logic [CW-1:0] cnt;
    logic [CW:0]   cnt_inc;
    logic          timeout, dec_exec, ex_ok;
    logic [3:0]    ex_code;

    // A ready arriving on the cycle the count would hit the limit still completes the access
    assign cnt_inc  = {1'b0, cnt} + 1'b1;
    assign timeout  = MEM_TIMEOUT != 0 && (st == FETCH || st == MEM) && !mem_ready
                      && cnt_inc == (CW+1)'(MEM_TIMEOUT);
    assign dec_exec = opcode inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI} || (DSP_EN && opcode == OP_DSP);
    assign state    = st;

    always_comb begin
        ex_ok = 1'b1;
        ex_code = 4'b0010;
        if (op == OP_BEQ) ex_code = 4'b0110;
        else if (op == OP_R) begin
            case (fn)
                6'b100000: ex_code = 4'b0010;
                6'b100010: ex_code = 4'b0110;
                6'b100100: ex_code = 4'b0000;
                6'b100101: ex_code = 4'b0001;
                6'b101010: ex_code = 4'b0111;
                default:   ex_ok = 1'b0;
            endcase
        end else if (op == OP_DSP) begin
            ex_code = sh == 5'b01000 ? 4'b1001 : 4'b1000;
            ex_ok = DSP_EN && fn == 6'b010000 && (sh == 5'b00000 || sh == 5'b01000);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st <= FETCH;
            cnt <= '0;
            op <= '0;
            fn <= '0;
            sh <= '0;
        end else begin
            st <= nxt;
            if (st == DECODE) begin
                op <= opcode;
                fn <= funct;
                sh <= shamt;
            end
            if (nxt != st && (nxt == FETCH || nxt == MEM)) cnt <= '0;
            else if ((st == FETCH || st == MEM) && !mem_ready) cnt <= cnt_inc[CW-1:0];
        end
    end

    always_comb begin
        nxt = st;
        case (st)
            FETCH:   nxt = timeout ? FAULT : mem_ready ? DECODE : FETCH;
            DECODE:  nxt = dec_exec ? EXEC : FETCH;
            EXEC:    nxt = (op == OP_LW || op == OP_SW) ? MEM : (op == OP_BEQ || !ex_ok) ? FETCH : WB;
            MEM:     nxt = timeout ? FAULT : !mem_ready ? MEM : op == OP_LW ? WB : FETCH;
            WB:      nxt = FETCH;
            FAULT:   nxt = FAULT;
            default: nxt = FETCH;
        endcase
    end

    always_comb begin
        {ir_write, pc_write, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a} = '0;
        pc_src = 2'b00;
        alu_src_b = 2'b00;
        alu_control = '0;
        done = 1'b0;
        illegal = 1'b0;
        fault = 1'b0;
        if (reset) begin
            mem_read = 1'b1;
            alu_src_b = 2'b01;
        end else begin
            case (st)
                FETCH: begin
                    mem_read = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                DECODE: begin
                    if (opcode == OP_JAL) begin
                        reg_write = 1'b1;
                        pc_write = 1'b1;
                        pc_src = 2'b10;
                        done = 1'b1;
                    end else if (opcode == OP_JR) begin
                        pc_write = 1'b1;
                        pc_src = 2'b11;
                        done = 1'b1;
                    end else illegal = !dec_exec;
                end
                EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = op inside {OP_LW, OP_SW, OP_ADDI} ? 2'b10 : 2'b00;
                    alu_control = ex_ok ? ALUCTRL_W'(ex_code) : '0;
                    illegal = !ex_ok;
                    pc_write = op == OP_BEQ && zero;
                    pc_src = op == OP_BEQ ? 2'b01 : 2'b00;
                    done = op == OP_BEQ;
                end
                MEM: begin
                    mem_read = op == OP_LW;
                    mem_write = op == OP_SW;
                    done = op == OP_SW && mem_ready;
                end
                WB: begin
                    reg_write = 1'b1;
                    reg_dst = op == OP_R || op == OP_DSP;
                    mem_to_reg = op == OP_LW;
                    done = 1'b1;
                end
                FAULT:   fault = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: scoreboard bench; each scheduled cycle carries its inputs and expected outputs.
module tb_multicycle_control_unit;
    localparam logic [5:0] OP_R = 6'b000000, OP_JAL = 6'b000011, OP_JR = 6'b000111, OP_BEQ = 6'b000100,
        OP_ADDI = 6'b001000, OP_LW = 6'b100011, OP_SW = 6'b101011, OP_DSP = 6'b011111;

    typedef struct packed {
        logic rst, rdy, z;
        logic [5:0] op, fn;
        logic [4:0] sh;
    } stim_t;

    typedef struct packed {
        logic [2:0] st;
        logic flt, ill, dn;
        logic [3:0] alu;
        logic [1:0] asb;
        logic asa, mtr, rd, rw, mw, mr;
        logic [1:0] pcs;
        logic pcw, irw;
    } outs_t;

    typedef struct packed {
        stim_t s;
        outs_t e;
    } item_t;

    logic clk = 1'b0, reset, zero, mem_ready;
    logic [5:0] opcode, funct;
    logic [4:0] shamt;
    logic ir_write, pc_write, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] pc_src, alu_src_b;
    logic [3:0] alu_control;
    logic [2:0] state;
    logic done, illegal, fault;
    outs_t act;
    item_t sq[$];
    outs_t exp_q[$];
    int ncmp = 0, nfail = 0;

    multicycle_control_unit #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .shamt(shamt), .zero(zero),
        .mem_ready(mem_ready), .ir_write(ir_write), .pc_write(pc_write), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .pc_src(pc_src), .alu_src_b(alu_src_b), .alu_control(alu_control),
        .state(state), .done(done), .illegal(illegal), .fault(fault)
    );

    always #5 clk = ~clk;

    assign act = {state, fault, illegal, done, alu_control, alu_src_b, alu_src_a, mem_to_reg, reg_dst,
                  reg_write, mem_write, mem_read, pc_src, pc_write, ir_write};

    function automatic stim_t si(logic rdy, logic [5:0] op = 6'd0, logic [5:0] fn = 6'd0,
                                 logic [4:0] sh = 5'd0, logic z = 1'b0, logic rst = 1'b0);
        stim_t s;
        s.rst = rst; s.rdy = rdy; s.z = z; s.op = op; s.fn = fn; s.sh = sh;
        return s;
    endfunction

    function automatic outs_t fo(logic rdy);
        outs_t o = '0;
        o.mr = 1'b1; o.asb = 2'b01; o.irw = rdy; o.pcw = rdy;
        return o;
    endfunction

    function automatic outs_t rst_o(logic [2:0] s);
        outs_t o = '0;
        o.st = s; o.mr = 1'b1; o.asb = 2'b01;
        return o;
    endfunction

    // k: 0 continue to EXEC, 1 jal, 2 jr, 3 unsupported
    function automatic outs_t dec_o(int k);
        outs_t o = '0;
        o.st = 3'd1;
        if (k == 1) begin o.rw = 1'b1; o.pcw = 1'b1; o.pcs = 2'b10; o.dn = 1'b1; end
        if (k == 2) begin o.pcw = 1'b1; o.pcs = 2'b11; o.dn = 1'b1; end
        if (k == 3) o.ill = 1'b1;
        return o;
    endfunction

    function automatic outs_t exe_o(logic [3:0] alu, logic [1:0] asb, logic ill, logic br, logic z);
        outs_t o = '0;
        o.st = 3'd2; o.asa = 1'b1; o.alu = alu; o.asb = asb; o.ill = ill;
        if (br) begin o.pcs = 2'b01; o.pcw = z; o.dn = 1'b1; end
        return o;
    endfunction

    function automatic outs_t mem_o(logic lw, logic rdy);
        outs_t o = '0;
        o.st = 3'd3; o.mr = lw; o.mw = !lw; o.dn = !lw && rdy;
        return o;
    endfunction

    function automatic outs_t wb_o(logic rd, logic mtr);
        outs_t o = '0;
        o.st = 3'd4; o.rw = 1'b1; o.rd = rd; o.mtr = mtr; o.dn = 1'b1;
        return o;
    endfunction

    function automatic outs_t flt_o();
        outs_t o = '0;
        o.st = 3'd5; o.flt = 1'b1;
        return o;
    endfunction

    task automatic sched(stim_t s, outs_t e);
        sq.push_back({s, e});
    endtask

    task automatic test_reset();
        item_t it;
        outs_t want;
        int n = 0;
        sched(si(1, OP_JAL, 0, 0, 0, 1), rst_o(0));
        sched(si(0), fo(0));
        while (sq.size() > 0) begin
            it = sq.pop_front();
            {reset, mem_ready, zero, opcode, funct, shamt} = it.s;
            exp_q.push_back(it.e);
            @(negedge clk);
            want = exp_q.pop_front();
            ncmp++;
            if (act !== want) begin
                nfail++;
                $display("FAIL reset step %0d: got %h want %h", n, act, want);
            end
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rtype();
        item_t it;
        outs_t want;
        int n = 0;
        logic [5:0] fns[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        logic [3:0] codes[5] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111};
        for (int i = 0; i < 5; i++) begin
            sched(si(1), fo(1));
            sched(si(0, OP_R, fns[i]), dec_o(0));
            sched(si(0, 6'h3f, 6'h3f, 5'h1f), exe_o(codes[i], 2'b00, 0, 0, 0));
            sched(si(0), wb_o(1, 0));
        end
        sched(si(0), fo(0));
        while (sq.size() > 0) begin
            it = sq.pop_front();
            {reset, mem_ready, zero, opcode, funct, shamt} = it.s;
            exp_q.push_back(it.e);
            @(negedge clk);
            want = exp_q.pop_front();
            ncmp++;
            if (act !== want) begin
                nfail++;
                $display("FAIL rtype step %0d: got %h want %h", n, act, want);
            end
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_ops();
        item_t it;
        outs_t want;
        int n = 0;
        sched(si(1), fo(1));
        sched(si(0, OP_LW), dec_o(0));
        sched(si(0), exe_o(4'b0010, 2'b10, 0, 0, 0));
        for (int i = 0; i < 3; i++) sched(si(0), mem_o(1, 0));
        sched(si(1), mem_o(1, 1));
        sched(si(0), wb_o(0, 1));
        sched(si(1), fo(1));
        sched(si(0, OP_SW), dec_o(0));
        sched(si(0), exe_o(4'b0010, 2'b10, 0, 0, 0));
        sched(si(1), mem_o(0, 1));
        sched(si(1), fo(1));
        sched(si(0, OP_ADDI), dec_o(0));
        sched(si(0), exe_o(4'b0010, 2'b10, 0, 0, 0));
        sched(si(0), wb_o(0, 0));
        sched(si(0), fo(0));
        while (sq.size() > 0) begin
            it = sq.pop_front();
            {reset, mem_ready, zero, opcode, funct, shamt} = it.s;
            exp_q.push_back(it.e);
            @(negedge clk);
            want = exp_q.pop_front();
            ncmp++;
            if (act !== want) begin
                nfail++;
                $display("FAIL mem_ops step %0d: got %h want %h", n, act, want);
            end
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_jump();
        item_t it;
        outs_t want;
        int n = 0;
        for (int i = 0; i < 2; i++) begin
            sched(si(1), fo(1));
            sched(si(0, OP_BEQ), dec_o(0));
            sched(si(0, 0, 0, 0, i == 0), exe_o(4'b0110, 2'b00, 0, 1, i == 0));
        end
        sched(si(1), fo(1));
        sched(si(0, OP_JAL), dec_o(1));
        sched(si(1), fo(1));
        sched(si(0, OP_JR), dec_o(2));
        sched(si(0), fo(0));
        while (sq.size() > 0) begin
            it = sq.pop_front();
            {reset, mem_ready, zero, opcode, funct, shamt} = it.s;
            exp_q.push_back(it.e);
            @(negedge clk);
            want = exp_q.pop_front();
            ncmp++;
            if (act !== want) begin
                nfail++;
                $display("FAIL branch_jump step %0d: got %h want %h", n, act, want);
            end
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        item_t it;
        outs_t want;
        int n = 0;
        sched(si(1), fo(1));
        sched(si(0, 6'h3f), dec_o(3));
        sched(si(1), fo(1));
        sched(si(0, OP_R, 6'b100001), dec_o(0));
        sched(si(0), exe_o(4'b0000, 2'b00, 1, 0, 0));
`ifdef MULTICYCLE_CTRL_DSP_EN
        sched(si(1), fo(1));
        sched(si(0, OP_DSP, 6'b010000, 5'b01000), dec_o(0));
        sched(si(0), exe_o(4'b1001, 2'b00, 0, 0, 0));
        sched(si(0), wb_o(1, 0));
        sched(si(1), fo(1));
        sched(si(0, OP_DSP, 6'b010000, 5'b00000), dec_o(0));
        sched(si(0), exe_o(4'b1000, 2'b00, 0, 0, 0));
        sched(si(0), wb_o(1, 0));
`else
        sched(si(1), fo(1));
        sched(si(0, OP_DSP, 6'b010000, 5'b01000), dec_o(3));
`endif
        sched(si(0), fo(0));
        while (sq.size() > 0) begin
            it = sq.pop_front();
            {reset, mem_ready, zero, opcode, funct, shamt} = it.s;
            exp_q.push_back(it.e);
            @(negedge clk);
            want = exp_q.pop_front();
            ncmp++;
            if (act !== want) begin
                nfail++;
                $display("FAIL illegal step %0d: got %h want %h", n, act, want);
            end
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        item_t it;
        outs_t want;
        int n = 0;
        sched(si(1), fo(1));
        sched(si(0, OP_JR), dec_o(2));
        for (int i = 0; i < 3; i++) sched(si(0), fo(0));
        sched(si(1), fo(1));
        sched(si(0, OP_JR), dec_o(2));
        for (int i = 0; i < 4; i++) sched(si(0), fo(0));
        sched(si(1), flt_o());
        sched(si(1), flt_o());
        sched(si(0, 0, 0, 0, 0, 1), rst_o(5));
        sched(si(0), fo(0));
        while (sq.size() > 0) begin
            it = sq.pop_front();
            {reset, mem_ready, zero, opcode, funct, shamt} = it.s;
            exp_q.push_back(it.e);
            @(negedge clk);
            want = exp_q.pop_front();
            ncmp++;
            if (act !== want) begin
                nfail++;
                $display("FAIL timeout step %0d: got %h want %h", n, act, want);
            end
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_mem();
        item_t it;
        outs_t want;
        int n = 0;
        sched(si(1), fo(1));
        sched(si(0, OP_SW), dec_o(0));
        sched(si(0), exe_o(4'b0010, 2'b10, 0, 0, 0));
        sched(si(0), mem_o(0, 0));
        sched(si(0, 0, 0, 0, 0, 1), rst_o(3));
        sched(si(0), fo(0));
        while (sq.size() > 0) begin
            it = sq.pop_front();
            {reset, mem_ready, zero, opcode, funct, shamt} = it.s;
            exp_q.push_back(it.e);
            @(negedge clk);
            want = exp_q.pop_front();
            ncmp++;
            if (act !== want) begin
                nfail++;
                $display("FAIL reset_mid_mem step %0d: got %h want %h", n, act, want);
            end
            n++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1);
    end

    initial begin
        {reset, mem_ready, zero, opcode, funct, shamt} = {1'b1, 19'd0};
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_rtype();
        test_mem_ops();
        test_branch_jump();
        test_illegal();
        test_timeout();
        test_reset_mid_mem();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
